uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
// - Parametrised UART receiver with programmable parity and a word FIFO, feeding a Nios PIO.
// - It is the successor to the fixed 8-bit single-word rx path and its rx_read handshake.
// - Serial line in; FIFO head, error flags and status out to CPU PIO ports.
// - The CPU pops one word per rx_read pulse.
// PARAMETERS
// DATA_W    8    data bits per frame (5..9), LSB first on the line
// BAUD_DIV  325  clk cycles per 16x oversample tick (50 MHz / (9600*16))
// FIFO_AW   2    FIFO address width; depth = 2**FIFO_AW entries
// PORTS
// clk_clk          in   1          system clock
// reset_reset_n    in   1          async active-low reset
// rx_serial        in   1          UART line, idle high, asynchronous to clk_clk
// rx_options       in   3          [0] parity enable, [1] odd parity (1) / even (0), [2] two stop bits
// rx_read          in   1          one-cycle pop strobe from CPU
// overrun_clr      in   1          one-cycle clear of sticky overrun
// rx_data          out  DATA_W     FIFO head data (first-word fall-through)
// rx_valid         out  1          FIFO not empty; rx_data/flags are valid
// rx_parity_err    out  1          parity error flag of head word
// rx_frame_err     out  1          stop-bit error flag of head word
// rx_overrun       out  1          sticky: a word was dropped because FIFO was full
// rx_count         out  FIFO_AW+1  words held in FIFO, 0..2**FIFO_AW
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0, FIFO empty, FSM IDLE, synchroniser regs = 1.
// - rx_serial passes a 2-FF synchroniser; all line decisions use the synchronised bit.
// - Tick: counter 0..BAUD_DIV-1, one-cycle tick at terminal count; free-running.
// - Sample counter 0..15 per bit, advanced on tick.
// - IDLE: falling edge of line -> START, sample counter cleared.
// - IDLE: rx_options is latched into frame options here; later changes do not affect the frame.
// - START: at sample 7 the line must still be low, else glitch -> IDLE with no push.
// - START: if the line is low at sample 7, the counter realigns so later samples fall mid-bit.
// - DATA: DATA_W bits sampled mid-bit, shifted in LSB first -> PARITY if enabled, else STOP.
// - PARITY: sample the bit; error = (XOR of data bits ^ bit) != odd.
// - Even parity makes the total count of ones even.
// - STOP: sample mid-bit; 0 -> frame_err.
// - STOP: with two stop bits, a second stop bit is sampled and either being 0 sets frame_err.
// - STOP: at the last stop sample, push {frame_err, parity_err, data} -> IDLE.
// - IDLE is re-entered at mid-stop, so back-to-back frames are accepted.
// - Push-to-rx_valid latency: 1 clk after the last stop sample.
// - FIFO holds DATA_W+2 bits per entry; rx_* outputs show the head directly (no read latency).
// - rx_read when rx_valid=1 pops the head; the next head is visible on the following cycle.
// - rx_read when empty is ignored.
// - Full with push and no pop: new word dropped, FIFO unchanged, rx_overrun <= 1.
// - Full with push and pop in the same cycle: both succeed, count unchanged, no overrun.
// - Empty with push and pop in the same cycle: pop ignored, word stored, count = 1.
// - Pointers wrap modulo 2**FIFO_AW; rx_count = wr_ptr - rd_ptr, using an extra MSB.
// - rx_overrun clears only on overrun_clr or reset.
// - If overrun_clr and a new overrun coincide, the set wins.
// - Reset mid-frame: partial frame discarded, no push; line re-acquired from IDLE after release.
// TESTING (BAUD_DIV=4, FIFO_AW=2, DATA_W=8)
// - 8N1 frame 0x55 -> rx_valid=1, rx_data=0x55, both err=0, count=1; rx_read -> valid=0, count=0.
// - Options 3'b001 (even), frame 0xA3 with parity bit 1 -> rx_data=0xA3, parity_err=1, frame_err=0.
// - Options 3'b011 (odd), frame 0xA3 with parity bit 1 -> parity_err=0.
// - Frame 0x3C with stop bit 0 -> frame_err=1, data=0x3C.
// - Options 3'b100, frame with second stop bit 0 -> frame_err=1.
// - Line low for 2 ticks only -> no push, FSM back to IDLE, count stays 0.
// - Send 0x01..0x05 with no reads -> count=4, rx_overrun=1, pops return 0x01..0x04.
// - Then overrun_clr -> rx_overrun=0.
// - With FIFO full, rx_read coincides with push of 0x06 -> count stays 4, overrun stays 0, 0x06 is last out.
// - Assert reset_reset_n=0 during data bit 3 -> all outputs 0; next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Brief    : CPU/PIO-side signal bundle of the UART receiver with word FIFO.
//            master = CPU/line side, slave = receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 2
);
  logic              rx_serial;
  logic [2:0]        rx_options;
  logic              rx_read;
  logic              overrun_clr;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_parity_err;
  logic              rx_frame_err;
  logic              rx_overrun;
  logic [FIFO_AW:0]  rx_count;

  modport master (
    output rx_serial, rx_options, rx_read, overrun_clr,
    input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_count
  );

  modport slave (
    input  rx_serial, rx_options, rx_read, overrun_clr,
    output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_count
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : 16x-oversampling UART receiver (5..9 data bits, optional
//            even/odd parity, one or two stop bits) feeding a first-word
//            fall-through FIFO of {frame_err, parity_err, data} words.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DATA_W   = 8,
  parameter int BAUD_DIV = 325,
  parameter int FIFO_AW  = 2
) (
  input  logic           clk_clk,
  input  logic           reset_reset_n,
  uart_rx_fifo_if.slave  bus
);

  localparam int               c_DEPTH    = 2 ** FIFO_AW;
  localparam int               c_BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int               c_BIT_W    = $clog2(DATA_W);
  localparam int               c_WORD_W   = DATA_W + 2;
  localparam logic [FIFO_AW:0] c_FULL_CNT = (FIFO_AW + 1)'(c_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases on a clock edge
  // --------------------------------------------------------------------------
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  // Two-stage release synchroniser for the external reset
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_rst_sync <= 2'b00;
    else                r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // --------------------------------------------------------------------------
  // Line synchroniser, edge detect and oversample tick
  // --------------------------------------------------------------------------
  logic [1:0]          r_sync;
  logic                r_line_d;
  logic                w_line;
  logic                w_fall;
  logic [c_BAUD_W-1:0] r_baud_cnt;
  logic                w_tick;

  // Bring the asynchronous line into the clock domain; remember previous level
  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync   <= 2'b11;
      r_line_d <= 1'b1;
    end else begin
      r_sync   <= {r_sync[0], bus.rx_serial};
      r_line_d <= r_sync[1];
    end
  end
  assign w_line = r_sync[1];
  assign w_fall = r_line_d & ~w_line;

  // Free-running divider producing one 16x oversample tick per BAUD_DIV clocks
  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n)    r_baud_cnt <= '0;
    else if (w_tick) r_baud_cnt <= '0;
    else             r_baud_cnt <= r_baud_cnt + 1'b1;
  end
  assign w_tick = (r_baud_cnt == c_BAUD_W'(BAUD_DIV - 1));

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_samp_cnt;
  logic [c_BIT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic [2:0]          r_opt;
  logic                r_par_err;
  logic                r_frame_err;
  logic                r_stop2;
  logic                w_mid;
  logic                w_start_chk;
  logic                w_last_bit;
  logic                w_push;
  logic [c_WORD_W-1:0] w_push_word;

  assign w_mid       = w_tick && (r_samp_cnt == 4'd15);
  assign w_start_chk = w_tick && (r_samp_cnt == 4'd7);
  assign w_last_bit  = (r_bit_cnt == c_BIT_W'(DATA_W - 1));
  // The stop sample taken in the push cycle is folded in directly
  assign w_push_word = {r_frame_err | ~w_line, r_par_err, r_shift};

  // State register
  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state and push strobe
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    case (r_state)
      S_IDLE:   if (w_fall) w_state_next = S_START;
      S_START:  if (w_start_chk) w_state_next = w_line ? S_IDLE : S_DATA;
      S_DATA:   if (w_mid && w_last_bit) w_state_next = r_opt[0] ? S_PARITY : S_STOP;
      S_PARITY: if (w_mid) w_state_next = S_STOP;
      S_STOP: begin
        // Leave at mid-stop so a following start edge is not missed
        if (w_mid && (!r_opt[2] || r_stop2)) begin
          w_push       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Sample counter, shift register, option latch and per-frame error bits
  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_samp_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_opt       <= '0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_stop2     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_samp_cnt  <= '0;
          r_bit_cnt   <= '0;
          r_par_err   <= 1'b0;
          r_frame_err <= 1'b0;
          r_stop2     <= 1'b0;
          if (w_fall) r_opt <= bus.rx_options;
        end
        S_START: begin
          // Restart at mid-start so every later 16-tick wrap lands mid-bit
          if (w_tick) r_samp_cnt <= w_start_chk ? 4'd0 : r_samp_cnt + 4'd1;
        end
        default: begin
          if (w_tick) r_samp_cnt <= r_samp_cnt + 4'd1;
          if (w_mid) begin
            if (r_state == S_DATA) begin
              r_shift   <= {w_line, r_shift[DATA_W-1:1]};
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_state == S_PARITY)
              r_par_err <= (((^r_shift) ^ w_line) != r_opt[1]);
            if (r_state == S_STOP) begin
              r_frame_err <= r_frame_err | ~w_line;
              r_stop2     <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Word FIFO (first-word fall-through)
  // --------------------------------------------------------------------------
  logic [c_WORD_W-1:0] r_mem [0:c_DEPTH-1];
  logic [FIFO_AW:0]    r_wr_ptr;
  logic [FIFO_AW:0]    r_rd_ptr;
  logic [FIFO_AW:0]    w_count;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_wr;
  logic                r_overrun;
  logic [c_WORD_W-1:0] w_head;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == c_FULL_CNT);
  assign w_pop   = bus.rx_read & ~w_empty;
  // A pop in the same cycle frees the slot for a push into a full FIFO
  assign w_wr    = w_push & (~w_full | w_pop);

  // Storage array; contents are only observed while the FIFO is non-empty
  always_ff @(posedge clk_clk) begin
    if (w_wr) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= w_push_word;
  end

  // Read/write pointers with an extra wrap bit
  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Sticky overrun; a new drop takes priority over a clear
  always_ff @(posedge clk_clk or negedge w_rst_n) begin
    if (!w_rst_n)                         r_overrun <= 1'b0;
    else if (w_push & w_full & ~w_pop)    r_overrun <= 1'b1;
    else if (bus.overrun_clr)             r_overrun <= 1'b0;
  end

  // Head word is forced to zero when empty so the outputs read 0 after reset
  assign w_head            = w_empty ? '0 : r_mem[r_rd_ptr[FIFO_AW-1:0]];
  assign bus.rx_data       = w_head[DATA_W-1:0];
  assign bus.rx_parity_err = w_head[DATA_W];
  assign bus.rx_frame_err  = w_head[DATA_W+1];
  assign bus.rx_valid      = ~w_empty;
  assign bus.rx_overrun    = r_overrun;
  assign bus.rx_count      = w_count;

endmodule
`default_nettype wire
